// File: rtl/tandy_scancode_sender.sv
// XT-style scancode/keybord_irq producer: buffers key events in a FIFO and frames each byte with an irq pulse.
// Optional auto-repeat of the last make event is enabled by defining TANDY_SENDER_TYPEMATIC_EN.
module tandy_scancode_sender #(
  parameter int          FIFO_DEPTH      = 8,
  parameter int          IRQ_HIGH_CYCLES = 2,
  parameter int          IRQ_GAP_CYCLES  = 2,
  parameter logic [15:0] TYPEMATIC_DELAY = 16'd500,
  parameter logic [15:0] TYPEMATIC_RATE  = 16'd100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [6:0] key_code,
  input  logic       key_extended,
  input  logic       key_break,
  output logic       key_ready,
  output logic [7:0] scancode,
  output logic       keybord_irq,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HI_LAST  = 16'(IRQ_HIGH_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(IRQ_GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRE_HI, PRE_LO, CODE_HI, CODE_LO} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  ent_q, ent_d;
  logic [7:0]  sc_q, sc_d;
  logic        irq_q, irq_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [8:0]  mem [FIFO_DEPTH];

  logic        fifo_empty, fifo_full, push, pop, launch, tm_fire;
  logic [8:0]  fifo_rd, launch_ent, held_ent;

  // Entry layout {ext, brk, code[6:0]}; the low byte is exactly the emitted code byte.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_rd    = mem[rd_ptr_q[AW-1:0]];
  assign push       = key_valid && !fifo_full;
  assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
  assign ovf_d      = ovf_q | (key_valid & fifo_full);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= {key_extended, key_break, key_code};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ent_d      = ent_q;
    sc_d       = sc_q;
    irq_d      = irq_q;
    pop        = 1'b0;
    launch     = 1'b0;
    launch_ent = fifo_rd;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          launch = 1'b1;
        end else if (tm_fire) begin
          launch     = 1'b1;
          launch_ent = held_ent;
        end
      end
      PRE_HI, CODE_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d   = '0;
          irq_d   = 1'b0;
          state_d = (state_q == PRE_HI) ? PRE_LO : CODE_LO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PRE_LO: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          sc_d    = ent_q[7:0];
          irq_d   = 1'b1;
          state_d = CODE_HI;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CODE_LO: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop    = 1'b1;
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Start of an event: the first byte (E0 or code) goes out on the same edge as the pop.
    if (launch) begin
      ent_d = launch_ent;
      irq_d = 1'b1;
      cnt_d = '0;
      if (launch_ent[8]) begin
        state_d = PRE_HI;
        sc_d    = 8'hE0;
      end else begin
        state_d = CODE_HI;
        sc_d    = launch_ent[7:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ent_q    <= '0;
      sc_q     <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ent_q    <= ent_d;
      sc_q     <= sc_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef TANDY_SENDER_TYPEMATIC_EN
  logic        held_vld_q, held_vld_d, tm_first_q, tm_first_d, tm_idle;
  logic [7:0]  held_q, held_d;
  logic [15:0] tm_cnt_q, tm_cnt_d;

  // Only a popped make arms the repeat; a popped break disarms it, a newer make replaces it.
  assign tm_idle  = (state_q == IDLE) && fifo_empty;
  assign tm_fire  = tm_idle && held_vld_q &&
                    (tm_cnt_q == ((tm_first_q ? TYPEMATIC_DELAY : TYPEMATIC_RATE) - 16'd1));
  assign held_ent = {held_q[7], 1'b0, held_q[6:0]};

  always_comb begin
    held_vld_d = held_vld_q;
    held_d     = held_q;
    tm_first_d = tm_first_q;
    tm_cnt_d   = tm_cnt_q;
    if (pop) begin
      held_vld_d = !fifo_rd[7];
      held_d     = {fifo_rd[8], fifo_rd[6:0]};
      tm_first_d = 1'b1;
      tm_cnt_d   = '0;
    end else if (tm_fire) begin
      tm_first_d = 1'b0;
      tm_cnt_d   = '0;
    end else if (tm_idle && held_vld_q) begin
      tm_cnt_d = tm_cnt_q + 16'd1;
    end else begin
      tm_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_vld_q <= 1'b0;
      held_q     <= '0;
      tm_first_q <= 1'b1;
      tm_cnt_q   <= '0;
    end else begin
      held_vld_q <= held_vld_d;
      held_q     <= held_d;
      tm_first_q <= tm_first_d;
      tm_cnt_q   <= tm_cnt_d;
    end
  end
`else
  logic tm_unused;
  assign tm_unused = ^{TYPEMATIC_DELAY, TYPEMATIC_RATE};
  assign tm_fire   = 1'b0;
  assign held_ent  = '0;
`endif

  assign key_ready   = !fifo_full;
  assign scancode    = sc_q;
  assign keybord_irq = irq_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign overflow    = ovf_q;
endmodule
